sub86_prefetch: RTL and testbench
=================================

# sub86_prefetch

Instruction prefetch unit that sits directly upstream of the sub86 core. It fetches 32-bit little-endian words from instruction memory over a req/ack handshake into a byte queue. It presents the 16-bit halfword at the core's fetch address on ID and drives the core's CE. CE is held low whenever the bytes at IA are not yet buffered or the data side requests a hold. A change of IA to any address other than the current or next sequential halfword flushes the queue and refetches from the new address, odd addresses included.

## Interface
- DEPTH, 16: queue capacity in bytes; power of two, at least 8.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTN  in  1  reset; asynchronous and active-low.
- IA  in  32  core fetch address (core PC), byte granular.
- ID  out  16  instruction halfword for the core: {byte[IA], byte[IA+1]}.
- CE  out  1  core clock enable.
- HOLD  in  1  data-side stall; forces CE low.
- MA  out  32  memory word address; MA[1:0] is always 0.
- MREQ  out  1  memory read request.
- MACK  in  1  memory acknowledge; MD is valid in the same cycle.
- MD  in  32  read data; byte at MA+k is MD[8k+7:8k].

## Operation
- Registers:
  - head_addr: address of the queue head byte.
  - count: 0..DEPTH.
  - nfa: next word address to fetch.
  - skip: 0..3, leading bytes to discard from the first word after a redirect.
  - ma_q: latched MA.
  - fetch state: IDLE / BUSY / DROP.
- Address match, each cycle:
  - hit0 = (IA == head_addr).
  - hit2 = (IA == head_addr+2), modulo 2^32.
  - off = hit2 ? 2 : 0.
  - valid = (hit0 & count ≥ 2) | (hit2 & count ≥ 4).
- Outputs:
  - ID = {q[head+off], q[head+off+1]} when valid, else 16'h0000.
  - CE = valid & ~HOLD.
- Pop: on an edge with hit2 & count ≥ 2, pop 2 bytes and set head_addr += 2. With hit0, nothing is popped.
- Flush: when neither hit0 nor hit2 holds, or hit2 with count < 2:
  - count = 0, head_addr = IA.
  - nfa = {IA[31:2], 2'b00}, skip = IA[1:0].
- Space test: space = (count + 4 ≤ DEPTH), evaluated before this cycle's pop.
- Memory request:
  - MREQ = (IDLE & space) | BUSY | DROP.
  - MA = IDLE ? nfa : ma_q.
  - MA is stable while MREQ is high and unacknowledged.
- FSM transitions (flush evaluated first):
  - IDLE & MREQ & ~MACK → BUSY; latch ma_q = nfa.
  - IDLE & MREQ & MACK → write, stay in IDLE.
  - BUSY & MACK → write, go to IDLE.
  - Flush while a request is outstanding and unacknowledged → DROP.
  - Flush in the same cycle as MACK → data discarded, go to IDLE.
  - DROP & MACK → data discarded, go to IDLE.
  - Flush in IDLE with no request → stay in IDLE.
- Write: 4−skip bytes, MD bytes skip..3 in order, appended at tail. Then nfa += 4 and skip = 0.
- Count update, same edge: count_next = count − pop + written.

## Timing
- Reset values:
  - CE = 0, ID = 0, MREQ = 0 (only after the first clock is MREQ driven from IDLE & space).
  - MA = 0, state IDLE, count 0, head_addr 0, nfa 0, skip 0.
- Reset mid-transaction: an outstanding request is abandoned. The memory side is required to ignore MREQ during reset, and any MACK after reset in IDLE without a request is ignored.
- Zero-wait memory, aligned redirect at cycle t:
  - flush on edge t;
  - MREQ/MA in t+1, with MACK in t+1;
  - CE = 1 in t+2.
- Redirect with IA[1:0] = 3: CE in t+3, since two words are needed.
- Sequential streaming with zero-wait memory sustains CE = 1 every cycle: 4 bytes in per cycle versus 2 consumed.
- Multi-cycle core ops that hold PC (hit0) keep CE = 1 with no refetch.

## Structure
- Shared package/include sub86_pkg:
  - fetch state encodings (IDLE = 2'b00, BUSY = 2'b01, DROP = 2'b10);
  - byte-order constant;
  - ID fill value 16'h0000.
- One sub-module, sub86_ibyteq: a circular byte buffer with DEPTH entries.
  - 0..4 byte write at tail.
  - Two-byte read at head+0 and head+off.
  - Pop of 0/2 and synchronous clear.
- The FSM, address compare and handshake live in the top module.

## Test plan
- Reset then IA = 0, memory returns 0x44332211 with zero wait → ID = 16'h1122 with CE = 1 at cycle 2; IA = 2 next → ID = 16'h3344.
- Memory with 3-cycle MACK latency, sequential IA → MA stable for the full request; MREQ high until ACK; CE low until the bytes arrive; no byte lost or duplicated over 64 halfwords.
- Jump to IA = 0x103 → MA = 0x100; bytes 0..2 discarded; MA = 0x104 fetched; ID = {byte 0x103, byte 0x104}; CE one cycle after the second ACK.
- Redirect while BUSY with ACK pending 2 cycles → state DROP; stale data not written; next MA equals the new target word.
- Core holds IA for 10 cycles (mul) with HOLD toggling → CE = ~HOLD, ID constant, count saturates at DEPTH, MREQ drops when no space.

Source files
------------

// File: rtl/sub86_pkg.sv
// Shared definitions for the sub86 instruction prefetch unit: fetch FSM encodings,
// memory byte-lane order and the halfword driven to the core when nothing is buffered.
package sub86_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'b00,
        FS_BUSY = 2'b01,
        FS_DROP = 2'b10
    } fetch_state_t;

    // Instruction memory is little-endian: the byte at MA+k sits in MD[8k+7:8k].
    localparam bit MD_LITTLE_ENDIAN = 1'b1;

    localparam logic [15:0] ID_FILL = 16'h0000;

    function automatic logic [7:0] md_lane(input logic [31:0] md, input logic [1:0] k);
        logic [7:0] b;
        if (MD_LITTLE_ENDIAN) begin
            b = md[8*k +: 8];
        end else begin
            b = md[8*(3-k) +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/sub86_ibyteq.sv
// Circular byte queue feeding the core: 0..4 byte append at the tail, two-byte peek at
// head+0 or head+2, pop of two bytes and a synchronous clear used on redirects.
module sub86_ibyteq
    import sub86_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic [2:0]  i_wr_n,
    input  logic [31:0] i_wr_data,
    input  logic        i_pop2,
    input  logic        i_off2,
    output logic [7:0]  o_b0,
    output logic [7:0]  o_b1
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_rd0;
    logic [AW-1:0] w_rd1;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_wr_n);
            if (i_pop2) begin
                r_rd_ptr <= r_rd_ptr + AW'(2);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!i_clear && (k < int'(i_wr_n))) begin
                r_mem[r_wr_ptr + AW'(k)] <= i_wr_data[8*k +: 8];
            end
        end
    end

    assign w_rd0 = r_rd_ptr + (i_off2 ? AW'(2) : AW'(0));
    assign w_rd1 = w_rd0 + AW'(1);
    assign o_b0  = r_mem[w_rd0];
    assign o_b1  = r_mem[w_rd1];

endmodule

// File: rtl/sub86_prefetch.sv
// sub86 instruction prefetch: fetches 32-bit words over MREQ/MACK into a byte queue and
// presents the halfword at IA on ID, gating the core with CE.
module sub86_prefetch
    import sub86_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] IA,
    output logic [15:0] ID,
    output logic        CE,
    input  logic        HOLD,
    output logic [31:0] MA,
    output logic        MREQ,
    input  logic        MACK,
    input  logic [31:0] MD,
    output logic [1:0]  DBG_STATE
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: MREQ high with MA stable until the cycle MACK is high; MD is taken in
    // that same cycle and the request counts as complete on that rising edge.
    fetch_state_t  r_state;
    logic [31:0]   r_head_addr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_nfa;
    logic [1:0]    r_skip;
    logic [31:0]   r_ma_q;
    logic          r_started;

    logic          w_hit0;
    logic          w_hit2;
    logic          w_cnt_ge2;
    logic          w_cnt_ge4;
    logic          w_valid;
    logic          w_pop;
    logic          w_flush;
    logic          w_space;
    logic          w_mreq;
    logic          w_write;
    logic [2:0]    w_wr_n;
    logic [2:0]    w_q_wr_n;
    logic [31:0]   w_wr_data;
    logic [CW-1:0] w_pop_n;
    logic [CW-1:0] w_wr_cnt;
    logic [7:0]    w_q_b0;
    logic [7:0]    w_q_b1;

    assign w_hit0    = (IA == r_head_addr);
    assign w_hit2    = (IA == (r_head_addr + 32'd2));
    assign w_cnt_ge2 = (r_count >= CW'(2));
    assign w_cnt_ge4 = (r_count >= CW'(4));
    assign w_valid   = (w_hit0 & w_cnt_ge2) | (w_hit2 & w_cnt_ge4);
    // A sequential step pops as soon as the old head halfword is present, even if the
    // new halfword still needs bytes; hit2 with fewer than 2 bytes is a redirect.
    assign w_pop     = w_hit2 & w_cnt_ge2;
    assign w_flush   = ~w_hit0 & ~w_pop;
    assign w_space   = (({1'b0, r_count} + (CW+1)'(4)) <= (CW+1)'(DEPTH));

    assign w_mreq    = r_started & (((r_state == FS_IDLE) & w_space) |
                                    (r_state == FS_BUSY) | (r_state == FS_DROP));
    assign w_write   = w_mreq & MACK & ~w_flush & (r_state != FS_DROP);
    assign w_wr_n    = 3'd4 - {1'b0, r_skip};
    assign w_q_wr_n  = w_write ? w_wr_n : 3'd0;
    assign w_pop_n   = w_pop ? CW'(2) : CW'(0);
    assign w_wr_cnt  = w_write ? CW'(w_wr_n) : CW'(0);

    // Leading bytes before the redirect target are dropped; the rest shift to lane 0.
    always_comb begin
        w_wr_data = '0;
        for (int k = 0; k < 4; k++) begin
            if ((k + int'(r_skip)) < 4) begin
                w_wr_data[8*k +: 8] = md_lane(MD, 2'(k + int'(r_skip)));
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= FS_IDLE;
            r_head_addr <= '0;
            r_count     <= '0;
            r_nfa       <= '0;
            r_skip      <= '0;
            r_ma_q      <= '0;
            r_started   <= 1'b0;
        end else begin
            r_started <= 1'b1;
            if (w_flush) begin
                r_head_addr <= IA;
                r_count     <= '0;
                r_nfa       <= {IA[31:2], 2'b00};
                r_skip      <= IA[1:0];
                // An unacknowledged request must still complete on the bus; its data is dropped.
                if (w_mreq && !MACK) begin
                    r_state <= FS_DROP;
                    if (r_state == FS_IDLE) begin
                        r_ma_q <= r_nfa;
                    end
                end else begin
                    r_state <= FS_IDLE;
                end
            end else begin
                if (w_pop) begin
                    r_head_addr <= r_head_addr + 32'd2;
                end
                r_count <= r_count - w_pop_n + w_wr_cnt;
                if (w_write) begin
                    r_nfa  <= r_nfa + 32'd4;
                    r_skip <= '0;
                end
                case (r_state)
                    FS_IDLE: begin
                        if (w_mreq && !MACK) begin
                            r_state <= FS_BUSY;
                            r_ma_q  <= r_nfa;
                        end
                    end
                    FS_BUSY, FS_DROP: begin
                        if (MACK) begin
                            r_state <= FS_IDLE;
                        end
                    end
                    default: r_state <= FS_IDLE;
                endcase
            end
        end
    end

    sub86_ibyteq #(
        .DEPTH(DEPTH)
    ) u_ibyteq (
        .i_clk     (CLK),
        .i_rst_n   (RSTN),
        .i_clear   (w_flush),
        .i_wr_n    (w_q_wr_n),
        .i_wr_data (w_wr_data),
        .i_pop2    (w_pop),
        .i_off2    (w_hit2),
        .o_b0      (w_q_b0),
        .o_b1      (w_q_b1)
    );

    assign ID        = w_valid ? {w_q_b0, w_q_b1} : ID_FILL;
    assign CE        = w_valid & ~HOLD;
    assign MREQ      = w_mreq;
    assign MA        = (r_state == FS_IDLE) ? r_nfa : r_ma_q;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_sub86_prefetch.sv
// Bench for sub86_prefetch: memory responder with programmable wait states, core model
// with expected-halfword queue, redirect vector table and hand-written corner sequences.
module tb_sub86_prefetch;
    import sub86_pkg::*;

    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [31:0] IA = '0;
    logic [15:0] ID;
    logic        CE;
    logic        HOLD = 1'b0;
    logic [31:0] MA;
    logic        MREQ;
    logic        MACK = 1'b0;
    logic [31:0] MD = '0;
    logic [1:0]  DBG_STATE;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 0;

    logic [31:0] ma_log[$];
    logic [15:0] exp_q[$];
    bit          pend = 1'b0;
    logic [31:0] pend_ma = '0;
    int          wc = 0;

    typedef struct {
        logic [31:0] ia;
        int          lat;
        int          exp_cyc;
        logic [15:0] exp_id;
    } vec_t;

    vec_t vecs[8];

    sub86_prefetch #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .IA        (IA),
        .ID        (ID),
        .CE        (CE),
        .HOLD      (HOLD),
        .MA        (MA),
        .MREQ      (MREQ),
        .MACK      (MACK),
        .MD        (MD),
        .DBG_STATE (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [7:0] lo;
        lo = a[7:0] + 8'd1;
        return 8'(lo * 8'd17) ^ a[15:8] ^ a[31:24];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] a);
        return {mbyte(a), mbyte(a + 32'd1)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Memory responder: MACK after mem_lat wait cycles, MA must hold for the whole request.
    always @(negedge CLK) begin
        if (!RSTN) begin
            pend = 1'b0;
            MACK = 1'b0;
        end else begin
            if (pend) begin
                n_checks++;
                if (!MREQ || (MA != pend_ma)) begin
                    n_fail++;
                    $display("FAIL ma_stable: MREQ=%0b MA=%h expected MREQ=1 MA=%h", MREQ, MA, pend_ma);
                end
            end
            if (MREQ) begin
                if (!pend) begin
                    pend    = 1'b1;
                    pend_ma = MA;
                    wc      = 0;
                    ma_log.push_back(MA);
                end
                if (wc >= mem_lat) begin
                    MACK = 1'b1;
                    MD   = mem_word(MA);
                    pend = 1'b0;
                end else begin
                    MACK = 1'b0;
                    wc++;
                end
            end else begin
                MACK = 1'b0;
            end
        end
    end

    task automatic settle();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((MREQ || (DBG_STATE != 2'b00)) && (n < 200));
        check("settle_mreq", {31'b0, MREQ}, 32'd0);
    endtask

    task automatic wait_ce(input int budget, output bit found, output logic [15:0] id, output int cyc);
        found = 1'b0;
        id    = '0;
        cyc   = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK);
            if (CE) begin
                found = 1'b1;
                id    = ID;
                cyc   = n;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL ce_timeout: CE never rose within %0d cycles", budget);
        end
    endtask

    // Core model: steps IA by 2 every time CE is seen, comparing ID against the queue.
    task automatic run_core(input logic [31:0] start, input int n, input int budget, output int span);
        int got;
        int cyc;
        int first;
        int last;
        logic [15:0] e;
        got = 0; cyc = 0; first = -1; last = -1;
        step();
        IA = start;
        exp_q.push_back(hw(start));
        while ((got < n) && (cyc < budget)) begin
            @(negedge CLK);
            cyc++;
            if (CE) begin
                e = exp_q.pop_front();
                check("stream_id", {16'b0, ID}, {16'b0, e});
                got++;
                if (first < 0) first = cyc;
                last = cyc;
                if (got < n) begin
                    step();
                    IA = IA + 32'd2;
                    exp_q.push_back(hw(IA));
                end
            end
        end
        check("stream_count", got, n);
        check("stream_q_empty", exp_q.size(), 0);
        exp_q.delete();
        span = last - first;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          span;
        bit          found;
        logic [15:0] id;
        int          cyc;
        logic [15:0] id_ref;

        vecs[0] = '{32'h0000_1000, 0, 2, 16'h0};
        vecs[1] = '{32'h0000_2001, 0, 2, 16'h0};
        vecs[2] = '{32'h0000_3002, 1, 3, 16'h0};
        vecs[3] = '{32'h0000_4003, 0, 3, 16'h0};
        vecs[4] = '{32'h0000_5003, 2, 7, 16'h0};
        vecs[5] = '{32'h0000_ABC0, 3, 5, 16'h0};
        vecs[6] = '{32'hFFFF_FFFE, 0, 2, 16'h0};
        vecs[7] = '{32'h0000_0103, 0, 3, 16'h0};
        for (int i = 0; i < 8; i++) vecs[i].exp_id = hw(vecs[i].ia);

        // Reset values.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_ce", {31'b0, CE}, 32'd0);
        check("rst_id", {16'b0, ID}, 32'd0);
        check("rst_mreq", {31'b0, MREQ}, 32'd0);
        check("rst_ma", MA, 32'd0);
        check("rst_state", {30'b0, DBG_STATE}, 32'd0);

        // First fetch after reset, zero-wait memory.
        @(posedge CLK);
        #1 RSTN = 1'b1;
        @(negedge CLK);
        check("c0_mreq", {31'b0, MREQ}, 32'd0);
        @(negedge CLK);
        check("c1_mreq", {31'b0, MREQ}, 32'd1);
        check("c1_ma", MA, 32'd0);
        @(negedge CLK);
        check("c2_ce", {31'b0, CE}, 32'd1);
        check("c2_id", {16'b0, ID}, 32'h0000_1122);
        step();
        IA = 32'd2;
        @(negedge CLK);
        check("c3_ce", {31'b0, CE}, 32'd1);
        check("c3_id", {16'b0, ID}, 32'h0000_3344);

        // Streaming: zero-wait sustains one halfword per cycle; 3-wait memory, odd start.
        mem_lat = 0;
        run_core(32'h0000_0200, 64, 400, span);
        check("stream_span_0wait", span, 63);
        mem_lat = 3;
        run_core(32'h0000_0401, 64, 2000, span);
        settle();

        // Redirect table.
        for (int i = 0; i < 8; i++) begin
            mem_lat = vecs[i].lat;
            step();
            IA = vecs[i].ia;
            ma_log.delete();
            wait_ce(100, found, id, cyc);
            if (found) begin
                check("redir_latency", cyc, vecs[i].exp_cyc);
                check("redir_id", {16'b0, id}, {16'b0, vecs[i].exp_id});
                check("redir_ma0", ma_log[0], {vecs[i].ia[31:2], 2'b00});
                if (vecs[i].ia[1:0] == 2'd3)
                    check("redir_ma1", ma_log[1], {vecs[i].ia[31:2], 2'b00} + 32'd4);
            end
            settle();
        end

        // Redirect while BUSY: stale word must be dropped, new target fetched next.
        mem_lat = 2;
        step();
        IA = 32'h0000_0600;
        ma_log.delete();
        step();
        step();
        IA = 32'h0000_0704;
        @(negedge CLK);
        check("drop_pre_state", {30'b0, DBG_STATE}, {30'b0, FS_BUSY});
        check("drop_pre_ma", MA, 32'h0000_0600);
        @(negedge CLK);
        check("drop_state", {30'b0, DBG_STATE}, {30'b0, FS_DROP});
        check("drop_mreq", {31'b0, MREQ}, 32'd1);
        check("drop_ma", MA, 32'h0000_0600);
        wait_ce(50, found, id, cyc);
        if (found) begin
            check("drop_id", {16'b0, id}, {16'b0, hw(32'h0000_0704)});
            check("drop_log_n", {31'b0, (ma_log.size() >= 2)}, 32'd1);
            check("drop_log1", ma_log[1], 32'h0000_0704);
        end

        // Multi-cycle op holding PC with HOLD toggling; queue fills and MREQ stops.
        mem_lat = 0;
        id_ref = hw(32'h0000_0704);
        for (int i = 0; i < 10; i++) begin
            step();
            HOLD = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check("hold_ce", {31'b0, CE}, {31'b0, ~HOLD});
            check("hold_id", {16'b0, ID}, {16'b0, id_ref});
        end
        step();
        HOLD = 1'b0;
        @(negedge CLK);
        check("full_mreq", {31'b0, MREQ}, 32'd0);
        check("full_ce", {31'b0, CE}, 32'd1);

        // Reset with a request outstanding.
        mem_lat = 3;
        step();
        IA = 32'h0000_0800;
        step();
        step();
        @(negedge CLK);
        check("mid_busy", {30'b0, DBG_STATE}, {30'b0, FS_BUSY});
        RSTN = 1'b0;
        #1;
        check("mid_rst_mreq", {31'b0, MREQ}, 32'd0);
        check("mid_rst_state", {30'b0, DBG_STATE}, 32'd0);
        check("mid_rst_ce", {31'b0, CE}, 32'd0);
        mem_lat = 0;
        step();
        step();
        RSTN = 1'b1;
        wait_ce(50, found, id, cyc);
        if (found) check("post_rst_id", {16'b0, id}, {16'b0, hw(32'h0000_0800)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
